// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard Wishbone slave.
package ps2_pkg;
    // I/O port offsets as seen on wb_adr_i ([2:1] of the byte address)
    localparam logic [1:0] PORT_DATA = 2'b00;   // 0x60
    localparam logic [1:0] PORT_STAT = 2'b10;   // 0x64

    // Sticky status bit positions in the 0x64 byte
    localparam int ST_OVR  = 4;
    localparam int ST_FERR = 5;
    localparam int ST_TOUT = 6;
    localparam int ST_PERR = 7;

    // Receiver frame state
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_e;
endpackage

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO holding received scancodes.
module ps2_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_C);
    assign dout  = mem_q[rd_q];

    // Pointer/count update; a pop frees a slot so push+pop succeeds when full
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        rd_d    = rd_q + AW'(do_pop);
        wr_d    = wr_q + AW'(do_push);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    // Pointer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/ps2_kbd_wb.sv
// PS/2 keyboard receiver with a Wishbone I/O slave at ports 0x60/0x64.
module ps2_kbd_wb
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_tga_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        ps2_clk_,
    input  logic        ps2_dat_,
    output logic        intr
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    logic c1_q, c2_q, cprev_q, d1_q, d2_q, fe;
    rx_state_e state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          rx_push, ev_perr, ev_ferr, ev_tout;

    logic ovr_q, ovr_d, ferr_q, ferr_d, tout_q, tout_d, perr_q, perr_d;
    logic        ack_q, ack_d, popq_q, popq_d;
    logic [15:0] dat_q, dat_d;
    logic [7:0]  last_q, last_d;
    logic        req, io_req, pop, flush, clr;
    logic [7:0]  head, status;
    logic        full, empty;

    logic unused_bits;
    assign unused_bits = ^{wb_sel_i[1], wb_dat_i[15:8], wb_dat_i[6:1]};

    assign fe       = cprev_q & ~c2_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign intr     = ~empty;
    assign status   = {perr_q, tout_q, ferr_q, ovr_q, 1'b0, 1'b1, 1'b0, ~empty};

    ps2_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
        .clk(wb_clk_i), .rst_n(wb_rst_i), .push(rx_push), .din(shreg_q),
        .pop(pop), .flush(flush), .dout(head), .full(full), .empty(empty)
    );

    // Frame receiver: start, 8 data LSB-first, odd parity, stop, with inter-edge timeout
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        rx_push  = 1'b0;
        ev_perr  = 1'b0;
        ev_ferr  = 1'b0;
        ev_tout  = 1'b0;
        if (state_q == S_IDLE || fe) tcnt_d = '0;
        else                         tcnt_d = tcnt_q + 1'b1;
        case (state_q)
            S_IDLE: if (fe && !d2_q) begin
                state_d  = S_DATA;
                bitcnt_d = '0;
            end
            S_DATA: if (fe) begin
                shreg_d  = {d2_q, shreg_q[7:1]};
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: if (fe) begin
                par_d   = d2_q;
                state_d = S_STOP;
            end
            S_STOP: if (fe) begin
                state_d = S_IDLE;
                ev_perr = ~^{shreg_q, par_q};
                ev_ferr = ~d2_q;
                rx_push = d2_q & ^{shreg_q, par_q};
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !fe && tcnt_q == TMAX) begin
            state_d = S_IDLE;
            ev_tout = 1'b1;
        end
    end

    // Bus decode: one-cycle ack, registered read data, pop deferred into the ack cycle
    always_comb begin
        req    = wb_stb_i & wb_cyc_i & ~ack_q;
        io_req = req & wb_tga_i;
        ack_d  = req;
        dat_d  = req ? 16'h0000 : dat_q;
        popq_d = 1'b0;
        flush  = 1'b0;
        clr    = 1'b0;
        if (io_req && !wb_we_i) begin
            if (wb_adr_i == PORT_DATA) begin
                if (!empty) begin
                    dat_d  = {8'h00, head};
                    popq_d = 1'b1;
                end else begin
                    dat_d  = {8'h00, last_q};
                end
            end else if (wb_adr_i == PORT_STAT) begin
                dat_d = {8'h00, status};
            end
        end
        if (io_req && wb_we_i && wb_adr_i == PORT_STAT && wb_sel_i[0]) begin
            flush = wb_dat_i[0];
            clr   = wb_dat_i[7];
        end
        pop    = ack_q & popq_q;
        last_d = pop ? head : last_q;
    end

    // Sticky flags: an event in the clear cycle keeps the flag set
    always_comb begin
        ovr_d  = (ovr_q  & ~clr) | (rx_push & full & ~pop);
        ferr_d = (ferr_q & ~clr) | ev_ferr;
        tout_d = (tout_q & ~clr) | ev_tout;
        perr_d = (perr_q & ~clr) | ev_perr;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            c1_q <= 1'b1; c2_q <= 1'b1; cprev_q <= 1'b1;
            d1_q <= 1'b1; d2_q <= 1'b1;
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
            ovr_q <= 1'b0; ferr_q <= 1'b0; tout_q <= 1'b0; perr_q <= 1'b0;
            ack_q    <= 1'b0;
            popq_q   <= 1'b0;
            dat_q    <= '0;
            last_q   <= '0;
        end else begin
            c1_q <= ps2_clk_; c2_q <= c1_q; cprev_q <= c2_q;
            d1_q <= ps2_dat_; d2_q <= d1_q;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            tcnt_q   <= tcnt_d;
            ovr_q <= ovr_d; ferr_q <= ferr_d; tout_q <= tout_d; perr_q <= perr_d;
            ack_q    <= ack_d;
            popq_q   <= popq_d;
            dat_q    <= dat_d;
            last_q   <= last_d;
        end
    end
endmodule
